// File: rtl/counter_sequencer.sv
// Run sequencer for an external up/down counter: load a preset, count until the target, then pulse done.
// Optional macro CTRL_TIMEOUT_EN adds a tick_en watchdog that aborts a run through ERR after TIMEOUT_TICKS.
module counter_sequencer #(
  parameter int WIDTH         = 4,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             ctr_load,
  output logic [WIDTH-1:0] ctr_in,
  output logic [1:0]       ctr_mode,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  state_t           state_q;
  logic             dir_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] ctrIn_q;
  logic             ctrLoad_q;
  logic [1:0]       ctrMode_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       runMode_d;
  logic             timeout_d;

  assign runMode_d = dir_q ? 2'b10 : 2'b01;

`ifdef CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_TICKS + 1);

  logic [TCW-1:0] tickCnt_q;
  logic           err_q;

  // The tick that would make the count reach TIMEOUT_TICKS ends the run.
  assign timeout_d = tick_en && (tickCnt_q == TCW'(TIMEOUT_TICKS - 1));
  assign err       = err_q;
`else
  localparam int unusedTimeoutTicks = TIMEOUT_TICKS;

  assign timeout_d = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      target_q  <= '0;
      ctrIn_q   <= '0;
      ctrLoad_q <= 1'b0;
      ctrMode_q <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      tickCnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            dir_q     <= dir;
            target_q  <= target;
            ctrIn_q   <= preset;
            ctrLoad_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            ctrLoad_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (tick_en) begin
            ctrLoad_q <= 1'b0;
            ctrMode_q <= runMode_d;
            state_q   <= RUN;
`ifdef CTRL_TIMEOUT_EN
            tickCnt_q <= '0;
`endif
          end
        end
        // Priority in RUN: abort, then target match, then watchdog.
        RUN: begin
          if (abort) begin
            ctrMode_q <= 2'b00;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (ctr_count == target_q) begin
            ctrMode_q <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (timeout_d) begin
            ctrMode_q <= 2'b00;
            busy_q    <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
            state_q   <= ERR;
          end else if (tick_en) begin
`ifdef CTRL_TIMEOUT_EN
            tickCnt_q <= tickCnt_q + 1'b1;
`endif
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctr_load = ctrLoad_q;
  assign ctr_in   = ctrIn_q;
  assign ctr_mode = ctrMode_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomised bench for counter_sequencer: emulates the external counter and predicts each run's
// phase boundaries (load edge, done edge) arithmetically from the tick pattern and preset/target distance.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_en = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] preset = '0;
  logic [3:0] target = '0;
  logic [3:0] ctr_count = '0;
  logic       ctr_load;
  logic [3:0] ctr_in;
  logic [1:0] ctr_mode;
  logic       busy;
  logic       done;
  logic       err;

  int  compared = 0;
  int  mismatched = 0;
  int  runIdx = 0;
  bit  holdCount = 1'b0;
  bit  tickArr[0:255];

  counter_sequencer #(.WIDTH(4), .TIMEOUT_TICKS(20)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .abort(abort),
    .dir(dir), .preset(preset), .target(target), .ctr_count(ctr_count),
    .ctr_load(ctr_load), .ctr_in(ctr_in), .ctr_mode(ctr_mode),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one clock cycle; the external counter loads or steps from what the sequencer showed before the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic a, input logic t);
    logic [3:0] nxt;
    reset   = r;
    start   = s;
    abort   = a;
    tick_en = t;
    nxt = ctr_count;
    if (ctr_load && t) nxt = ctr_in;
    else if (t && ctr_mode == 2'b01) nxt = ctr_count + 4'd1;
    else if (t && ctr_mode == 2'b10) nxt = ctr_count - 4'd1;
    if (holdCount) nxt = 4'd0;
    @(posedge clk);
    #1;
    ctr_count = nxt;
  endtask

  task automatic checkIdle(input string tag, input logic checkIn);
    checkOutput($sformatf("%s ctr_load", tag), {7'd0, ctr_load}, 8'd0);
    checkOutput($sformatf("%s ctr_mode", tag), {6'd0, ctr_mode}, 8'd0);
    checkOutput($sformatf("%s busy", tag), {7'd0, busy}, 8'd0);
    checkOutput($sformatf("%s done", tag), {7'd0, done}, 8'd0);
    checkOutput($sformatf("%s err", tag), {7'd0, err}, 8'd0);
    if (checkIn) checkOutput($sformatf("%s ctr_in", tag), {4'd0, ctr_in}, 8'd0);
  endtask

  // One run: predicts the load edge from the first tick, and the done edge from the number
  // of counter steps separating preset and target in the chosen direction.
  task automatic doRun(input logic [3:0] p, input logic [3:0] t, input logic d, input int abortAt);
    int         eL, dEdge, k, seen, lastE, busyEnd;
    bit         aborted, s;
    logic [3:0] kk;
    logic       expLoad, expBusy, expDone;
    logic [1:0] expMode;
    for (int e = 0; e < 256; e++) tickArr[e] = (e % 4 == 0) || ($urandom_range(0, 1) == 1);
    eL = -1;
    for (int e = 1; e < 256; e++) if (tickArr[e] && eL < 0) eL = e;
    kk = d ? p - t : t - p;
    k = int'(kk);
    dEdge = eL + 1;
    if (k != 0) begin
      seen = 0;
      for (int e = eL + 1; e < 256; e++) begin
        if (tickArr[e]) begin
          seen++;
          if (seen == k) begin
            dEdge = e + 1;
            break;
          end
        end
      end
    end
    aborted = (abortAt > 0) && (abortAt <= dEdge);
    lastE   = aborted ? abortAt + 1 : dEdge + 1;
    busyEnd = aborted ? abortAt : dEdge + 1;
    for (int e = 0; e <= lastE; e++) begin
      s = (e == 0) ? 1'b1 : (e <= busyEnd && $urandom_range(0, 3) == 0);
      if (e == 0) begin
        dir = d; preset = p; target = t;
      end else if (s) begin
        dir = 1'($urandom_range(0, 1)); preset = 4'($urandom); target = 4'($urandom);
      end
      applyStimulus(1'b0, s, (e == abortAt), tickArr[e]);
      expLoad = 1'b0; expBusy = 1'b0; expDone = 1'b0; expMode = 2'b00;
      if (!(aborted && e >= abortAt)) begin
        if (e < eL) begin
          expLoad = 1'b1; expBusy = 1'b1;
        end else if (e < dEdge) begin
          expBusy = 1'b1; expMode = d ? 2'b10 : 2'b01;
        end else if (e == dEdge) begin
          expDone = 1'b1;
        end
      end
      checkOutput($sformatf("run%0d e%0d ctr_load", runIdx, e), {7'd0, ctr_load}, {7'd0, expLoad});
      checkOutput($sformatf("run%0d e%0d busy", runIdx, e), {7'd0, busy}, {7'd0, expBusy});
      checkOutput($sformatf("run%0d e%0d ctr_mode", runIdx, e), {6'd0, ctr_mode}, {6'd0, expMode});
      checkOutput($sformatf("run%0d e%0d done", runIdx, e), {7'd0, done}, {7'd0, expDone});
      checkOutput($sformatf("run%0d e%0d err", runIdx, e), {7'd0, err}, 8'd0);
      if (expLoad) checkOutput($sformatf("run%0d e%0d ctr_in", runIdx, e), {4'd0, ctr_in}, {4'd0, p});
    end
    runIdx++;
  endtask

  initial begin
    $display("[TB] counter_sequencer bench starting");

    // Reset overrides a simultaneous start/abort/tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkIdle("reset", 1'b1);

    // Start together with abort is ignored; abort alone in IDLE does nothing.
    preset = 4'd9; target = 4'd2;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkIdle("start+abort", 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkIdle("abort idle", 1'b1);

    // Directed runs: up count, down count through wrap, preset equal to target,
    // and abort coinciding with the target match.
    doRun(4'd3, 4'd7, 1'b0, -1);
    doRun(4'd2, 4'd14, 1'b1, -1);
    doRun(4'd5, 4'd5, 1'b0, -1);
    doRun(4'd6, 4'd6, 1'b1, 2);
    doRun(4'd0, 4'd1, 1'b0, 1);

    // Reset in the middle of a long run, then a normal run afterwards.
    dir = 1'b0; preset = 4'd1; target = 4'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrun busy", {7'd0, busy}, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkIdle("midrun reset", 1'b1);
    doRun(4'd12, 4'd4, 1'b0, -1);

    // Randomised runs, back to back, some aborted.
    for (int i = 0; i < 16; i++) begin
      doRun(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1);
    end

    // Counter stuck at 0 with target 9: watchdog behaviour.
    holdCount = 1'b1;
    ctr_count = 4'd0;
    dir = 1'b0; preset = 4'd0; target = 4'd9;
`ifdef CTRL_TIMEOUT_EN
    for (int e = 0; e <= 22; e++) begin
      applyStimulus(1'b0, (e == 0), 1'b0, 1'b1);
      checkOutput($sformatf("timeout e%0d err", e), {7'd0, err}, {7'd0, (e == 21)});
      checkOutput($sformatf("timeout e%0d busy", e), {7'd0, busy}, {7'd0, (e <= 20)});
      checkOutput($sformatf("timeout e%0d done", e), {7'd0, done}, 8'd0);
    end
`else
    for (int e = 0; e <= 30; e++) begin
      applyStimulus(1'b0, (e == 0), 1'b0, 1'b1);
      checkOutput($sformatf("noTimeout e%0d err", e), {7'd0, err}, 8'd0);
      checkOutput($sformatf("noTimeout e%0d busy", e), {7'd0, busy}, 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
`endif
    checkIdle("after stuck run", 1'b0);
    holdCount = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
